trace_capture_buffer: RTL

Parametrised on-chip trace recorder for the MIPS_32 datapath. It records CHANNELS observed buses (e.g. readDataMem, ALUa, ALUb), each WIDTH bits wide, into a DEPTH-entry FIFO. Each entry carries a cycle timestamp. Capture runs either on-change or every cycle. A consumer (bench or debug port) drains the FIFO through a valid/enable handshake. It sits beside top and is instantiated by the system bench in place of ad-hoc console monitoring.

---
 rtl/trace_capture_buffer_if.sv | 30 +++
 rtl/trace_capture_buffer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer_if.sv
// Bus bundle for the trace capture buffer: capture controls, observed data
// and the pop side of the FIFO.
interface trace_capture_buffer_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 16,
  parameter int STAMP_W  = 16
);
  logic                        enable;
  logic                        clear;
  logic [WIDTH*CHANNELS-1:0]   ch_data;
  logic                        rd_en;
  logic                        rd_valid;
  logic [WIDTH*CHANNELS-1:0]   rd_data;
  logic [STAMP_W-1:0]          rd_stamp;
  logic [$clog2(DEPTH):0]      count;
  logic                        full;
  logic                        empty;
  logic                        overflow;

  modport master (
    output enable, clear, ch_data, rd_en,
    input  rd_valid, rd_data, rd_stamp, count, full, empty, overflow
  );

  modport slave (
    input  enable, clear, ch_data, rd_en,
    output rd_valid, rd_data, rd_stamp, count, full, empty, overflow
  );
endinterface

// File: rtl/trace_capture_buffer.sv
// Trace recorder: captures CHANNELS observed buses plus a cycle timestamp into
// a DEPTH-entry FIFO, on change (MODE=0) or every enabled cycle (MODE=1).
module trace_capture_buffer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 16,
  parameter int MODE     = 0,
  parameter int STAMP_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  trace_capture_buffer_if.slave bus
);
  localparam int DW = WIDTH * CHANNELS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0]      mem_data_q  [DEPTH];
  logic [STAMP_W-1:0] mem_stamp_q [DEPTH];

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;
  logic               primed_q, primed_d;
  logic [DW-1:0]      prev_q, prev_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DW-1:0]      rd_data_q, rd_data_d;
  logic [STAMP_W-1:0] rd_stamp_q, rd_stamp_d;

  logic cap_req;
  logic rd_accept;
  logic wr_accept;

  // A pop while full frees the slot the incoming capture lands in.
  always_comb begin
    rd_accept = bus.rd_en && !empty_q;
    if (MODE != 0) cap_req = bus.enable;
    else           cap_req = bus.enable && (!primed_q || (bus.ch_data != prev_q));
    wr_accept = cap_req && (!full_q || rd_accept);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    primed_d   = primed_q;
    prev_d     = prev_q;
    stamp_d    = stamp_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_stamp_d = rd_stamp_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      primed_d   = 1'b0;
      prev_d     = '0;
      stamp_d    = '0;
    end else begin
      if (rd_accept) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_valid_d = 1'b1;
        rd_data_d  = mem_data_q[rd_ptr_q];
        rd_stamp_d = mem_stamp_q[rd_ptr_q];
      end
      // A dropped capture leaves prev/primed alone so MODE=0 retries it.
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        prev_d   = bus.ch_data;
        primed_d = 1'b1;
      end else if (cap_req) begin
        overflow_d = 1'b1;
      end
      count_d = count_q + CW'(wr_accept) - CW'(rd_accept);
      if (bus.enable) stamp_d = stamp_q + 1'b1;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst && !bus.clear && wr_accept) begin
      mem_data_q[wr_ptr_q]  <= bus.ch_data;
      mem_stamp_q[wr_ptr_q] <= stamp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      primed_q   <= 1'b0;
      prev_q     <= '0;
      stamp_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_stamp_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      primed_q   <= primed_d;
      prev_q     <= prev_d;
      stamp_q    <= stamp_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_stamp_q <= rd_stamp_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_stamp = rd_stamp_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.overflow = overflow_q;
endmodule
